// File: rtl/color_sched_pkg.sv
// Shared types, constants and legality helpers for the colour command scheduler.
package color_sched_pkg;

  // Command encoding seen on each requester's command slice and on fsm_in.
  typedef enum logic [1:0] {
    CMD_RED    = 2'd0,
    CMD_TOGGLE = 2'd1,
    CMD_HSV    = 2'd2,
    CMD_NOP    = 2'd3
  } cmd_t;

  // Scheduler's private copy of where the colour FSM should be.
  typedef enum logic [1:0] {
    M_BLUE = 2'd0,
    M_RED  = 2'd1,
    M_HSV  = 2'd2
  } mirror_t;

  typedef enum logic [2:0] {
    Sched_Idle  = 3'd0,
    Sched_Drive = 3'd1,
    Sched_Check = 3'd2,
    Sched_Done  = 3'd3,
    HSV_Hold    = 3'd4
  } sched_state_t;

  // fsm_in value that causes no transition in any colour state.
  localparam logic [1:0] FSM_IDLE_IN = 2'h3;
  localparam logic [1:0] OUT_BLUE    = 2'h1;
  localparam logic [1:0] OUT_RED     = 2'h2;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Whether a command may be issued from the given colour state.
  function automatic logic cmd_legal(input mirror_t m, input cmd_t c);
    logic ok;
    ok = 1'b0;
    case (c)
      CMD_TOGGLE: ok = (m == M_BLUE) || (m == M_RED);
      CMD_HSV:    ok = (m == M_RED);
      CMD_RED:    ok = (m == M_RED) || (m == M_HSV);
      default:    ok = 1'b1;
    endcase
    return ok;
  endfunction

  // Colour state after a legal command has been driven.
  function automatic mirror_t next_mirror(input mirror_t m, input cmd_t c);
    mirror_t n;
    n = m;
    case (c)
      CMD_TOGGLE: n = (m == M_BLUE) ? M_RED : M_BLUE;
      CMD_HSV:    n = M_HSV;
      CMD_RED:    n = M_RED;
      default:    n = m;
    endcase
    return n;
  endfunction

  // fsm_out the colour FSM must present once it sits in state m.
  function automatic logic [1:0] expected_out(input mirror_t m);
    return (m == M_BLUE) ? OUT_BLUE : OUT_RED;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter
  import color_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  localparam logic [IDX_W:0] N_EXT = (IDX_W + 1)'(NUM_REQ);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [IDX_W-1:0]     w_off;
  logic [IDX_W:0]       w_sum;

  // Doubling the vector turns the wrap-around into a plain part-select.
  assign w_dbl = {req, req};
  assign w_rot = w_dbl[ptr +: NUM_REQ];

  // Lowest set bit of the rotated vector is the distance from ptr to the winner.
  always_comb begin
    w_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = IDX_W'(k);
    end
  end

  assign w_sum = {1'b0, ptr} + {1'b0, w_off};
  assign idx   = (w_sum >= N_EXT) ? IDX_W'(w_sum - N_EXT) : w_sum[IDX_W-1:0];
  assign valid = |req;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
      assign gnt[gi] = valid && (idx == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/color_cmd_scheduler.sv
// Arbitrates colour commands from NUM_REQ requesters, filters illegal ones,
// drives the colour FSM for one cycle, checks its response, and enforces a
// minimum dwell after entering HSV.
module color_cmd_scheduler
  import color_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [2*NUM_REQ-1:0] req_cmd,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic                 err,
  output logic [1:0]           fsm_in,
  input  logic [1:0]           fsm_out,
  output logic                 busy,
  output logic                 hsv_active
);

  localparam int IDX_W = idx_width(NUM_REQ);

  logic               w_valid;
  logic [NUM_REQ-1:0] w_win;
  logic [IDX_W-1:0]   w_idx;
  cmd_t               w_cmd;
  logic               w_legal;

  sched_state_t       r_state;
  mirror_t            r_mirror;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_idx;
  cmd_t               r_cmd;
  logic               r_to_hold;
  logic [3:0]         r_cnt;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_done;
  logic               r_err;
  logic [1:0]         r_fsm_in;
  logic               r_busy;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req   (req),
    .ptr   (r_ptr),
    .valid (w_valid),
    .gnt   (w_win),
    .idx   (w_idx)
  );

  // Winner's command and its legality against the colour state we believe in.
  assign w_cmd   = cmd_t'(req_cmd[{w_idx, 1'b0} +: 2]);
  assign w_legal = cmd_legal(r_mirror, w_cmd);

  // Scheduler FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= Sched_Idle;
      r_mirror  <= M_RED;
      r_ptr     <= '0;
      r_idx     <= '0;
      r_cmd     <= CMD_NOP;
      r_to_hold <= 1'b0;
      r_cnt     <= '0;
      r_gnt     <= '0;
      r_done    <= '0;
      r_err     <= 1'b0;
      r_fsm_in  <= FSM_IDLE_IN;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        Sched_Idle: begin
          r_done <= '0;
          r_err  <= 1'b0;
          if (w_valid) begin
            r_gnt     <= w_win;
            r_idx     <= w_idx;
            r_cmd     <= w_cmd;
            r_busy    <= 1'b1;
            r_to_hold <= w_legal && (w_cmd == CMD_HSV);
            if (w_legal && (w_cmd != CMD_NOP)) begin
              r_state  <= Sched_Drive;
              r_fsm_in <= w_cmd;
            end else begin
              // Nothing to drive: report straight away, flagging illegal commands.
              r_state <= Sched_Done;
              r_done  <= w_win;
              r_err   <= !w_legal;
            end
          end
        end
        Sched_Drive: begin
          r_fsm_in <= FSM_IDLE_IN;
          r_mirror <= next_mirror(r_mirror, r_cmd);
          r_state  <= Sched_Check;
        end
        Sched_Check: begin
          // Colour FSM has taken the command by now; a mismatch is reported but
          // the mirror keeps its intended value.
          r_done  <= r_gnt;
          r_err   <= (fsm_out != expected_out(r_mirror));
          r_state <= Sched_Done;
        end
        Sched_Done: begin
          r_done <= '0;
          r_err  <= 1'b0;
          r_gnt  <= '0;
          r_ptr  <= (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
          if (r_to_hold) begin
            r_state <= HSV_Hold;
            r_cnt   <= 4'(HOLD_CYCLES - 1);
          end else begin
            r_state <= Sched_Idle;
            r_busy  <= 1'b0;
          end
        end
        HSV_Hold: begin
          if (r_cnt == 4'd0) begin
            r_state <= Sched_Idle;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= Sched_Idle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt        = r_gnt;
  assign done       = r_done;
  assign err        = r_err;
  assign fsm_in     = r_fsm_in;
  assign busy       = r_busy;
  assign hsv_active = (r_mirror == M_HSV);

endmodule
